// File: rtl/irqc_pkg.sv
// Shared types and constants for the irq_controller slice.
// Round-robin arbitration is enabled by defining IRQC_RR_EN.
package irqc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } irqc_state_t;

  localparam logic [1:0] IRQC_A_MASK   = 2'd0;
  localparam logic [1:0] IRQC_A_PEND   = 2'd1;
  localparam logic [1:0] IRQC_A_ACTIVE = 2'd2;

  localparam int IRQC_BUSY_BIT = 31;

  // Width of a source index; kept at least 1 so a single-source build still has a field.
  function automatic int irqc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irqc_arbiter.sv
// Combinational winner selection: first eligible index at or above ptr, wrapping.
// A constant ptr of zero degenerates to fixed priority with index 0 highest.
module irqc_arbiter
  import irqc_pkg::*;
#(
  parameter int  N_SRC = 4,
  localparam int IDW   = irqc_idx_w(N_SRC)
) (
  input  logic [N_SRC-1:0] eligible,
  input  logic [IDW-1:0]   ptr,
  output logic [IDW-1:0]   winner,
  output logic             valid
);

  // Scan from the farthest offset down so the nearest eligible index is written last.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    valid  = 1'b0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_SRC) begin
        idx = idx - N_SRC;
      end else begin
        idx = idx;
      end
      if (eligible[idx]) begin
        winner = IDW'(idx);
        valid  = 1'b1;
      end else begin
        valid  = valid;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Multi-source interrupt controller in front of the core's single irq/irq_ack/irq_addr port.
// Define IRQC_RR_EN for round-robin arbitration; the default build is fixed priority.
module irq_controller
  import irqc_pkg::*;
#(
  parameter int          N_SRC      = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0000,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0040
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src,
  output logic             irq,
  input  logic             irq_ack,
  output logic [31:0]      irq_addr,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wd,
  output logic [31:0]      cfg_rd
);

  localparam int IDW = irqc_idx_w(N_SRC);

  logic [N_SRC-1:0] src_q, pend, pend_nxt, mask, rise, eligible;
  logic [IDW-1:0]   act_id, act_id_nxt, winner, ptr;
  logic             win_valid, ack_done;
  logic             cfg_wd_unused;
  irqc_state_t      state, state_nxt;

  assign rise          = src & ~src_q;
  assign eligible      = pend & mask;
  assign ack_done      = (state == REQ) && irq_ack;
  assign cfg_wd_unused = ^cfg_wd[31:N_SRC];

`ifdef IRQC_RR_EN
  logic [IDW-1:0] rr_ptr;

  // Pointer moves just past the source whose service completed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (ack_done) begin
      rr_ptr <= (int'(act_id) == N_SRC - 1) ? '0 : act_id + IDW'(1);
    end else begin
      rr_ptr <= rr_ptr;
    end
  end

  assign ptr = rr_ptr;
`else
  assign ptr = '0;
`endif

  irqc_arbiter #(.N_SRC(N_SRC)) u_arb (
    .eligible (eligible),
    .ptr      (ptr),
    .winner   (winner),
    .valid    (win_valid)
  );

  // State, latched winner, edge history, pending and mask registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      act_id <= '0;
      src_q  <= '0;
      pend   <= '0;
      mask   <= '0;
    end else begin
      state  <= state_nxt;
      act_id <= act_id_nxt;
      src_q  <= src;
      pend   <= pend_nxt;
      if (cfg_we && (cfg_addr == IRQC_A_MASK)) begin
        mask <= cfg_wd[N_SRC-1:0];
      end else begin
        mask <= mask;
      end
    end
  end

  // Next state and pending update; new edges are OR-ed in last so a set beats any clear.
  always_comb begin
    state_nxt  = state;
    act_id_nxt = act_id;
    pend_nxt   = pend;
    case (state)
      IDLE: begin
        if (win_valid) begin
          state_nxt  = REQ;
          act_id_nxt = winner;
        end else begin
          state_nxt  = IDLE;
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_nxt        = GAP;
          pend_nxt[act_id] = 1'b0;
        end else begin
          state_nxt        = REQ;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (cfg_we && (cfg_addr == IRQC_A_PEND)) begin
      pend_nxt = pend_nxt & ~cfg_wd[N_SRC-1:0];
    end else begin
      pend_nxt = pend_nxt;
    end
    pend_nxt = pend_nxt | rise;
  end

  assign irq      = (state == REQ);
  assign irq_addr = VEC_BASE + (32'(act_id) * VEC_STRIDE);

  // Config read mux, zero-extended.
  always_comb begin
    cfg_rd = 32'h0000_0000;
    case (cfg_addr)
      IRQC_A_MASK:   cfg_rd[N_SRC-1:0] = mask;
      IRQC_A_PEND:   cfg_rd[N_SRC-1:0] = pend;
      IRQC_A_ACTIVE: begin
        cfg_rd[IRQC_BUSY_BIT] = (state != IDLE);
        cfg_rd[IDW-1:0]       = act_id;
      end
      default:       cfg_rd = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with hand-computed expectations.
module tb_irq_controller;
  import irqc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  src = 4'h0;
  logic        irq;
  logic        irq_ack = 1'b0;
  logic [31:0] irq_addr;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [31:0] cfg_wd = 32'h0;
  logic [31:0] cfg_rd;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_first, exp_second;

  irq_controller #(
    .N_SRC(4), .VEC_BASE(32'h0000_0000), .VEC_STRIDE(32'h0000_0040)
  ) dut (
    .clk(clk), .rst(rst), .src(src), .irq(irq), .irq_ack(irq_ack), .irq_addr(irq_addr),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wd(cfg_wd), .cfg_rd(cfg_rd)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wd = d;
    step();
    cfg_we = 1'b0; cfg_wd = 32'h0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    cfg_addr = a;
    #1;
    check_eq(tag, cfg_rd, exp);
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
  endtask

  initial begin
`ifdef IRQC_RR_EN
    exp_first = 32'hC0; exp_second = 32'h00;
`else
    exp_first = 32'h00; exp_second = 32'hC0;
`endif
    repeat (3) step();
    rst = 1'b1;
    step();
    check_eq("rst_irq", {31'h0, irq}, 32'h0);
    check_eq("rst_addr", irq_addr, 32'h0);
    rd_chk("rst_mask", IRQC_A_MASK, 32'h0);
    rd_chk("rst_pend", IRQC_A_PEND, 32'h0);
    rd_chk("rst_active", IRQC_A_ACTIVE, 32'h0);
    rd_chk("rst_resv", 2'd3, 32'h0);

    // single source 2
    wr(IRQC_A_MASK, 32'h4);
    rd_chk("mask_rb", IRQC_A_MASK, 32'h4);
    src = 4'b0100;
    step();
    check_eq("s2_t1_irq", {31'h0, irq}, 32'h0);
    step();
    check_eq("s2_t2_irq", {31'h0, irq}, 32'h1);
    check_eq("s2_addr", irq_addr, 32'h80);
    rd_chk("s2_active", IRQC_A_ACTIVE, 32'h8000_0002);
    src = 4'b0000;
    step();
    check_eq("s2_hold", {31'h0, irq}, 32'h1);
    ack();
    check_eq("s2_gap", {31'h0, irq}, 32'h0);
    step();
    check_eq("s2_idle", {31'h0, irq}, 32'h0);
    rd_chk("s2_pend", IRQC_A_PEND, 32'h0);

    // masked pending then unmask
    wr(IRQC_A_MASK, 32'h0);
    src = 4'b0010; step(); src = 4'b0000; step();
    rd_chk("mp_pend", IRQC_A_PEND, 32'h2);
    check_eq("mp_irq0", {31'h0, irq}, 32'h0);
    wr(IRQC_A_MASK, 32'h2);
    check_eq("mp_wr_irq", {31'h0, irq}, 32'h0);
    step();
    check_eq("mp_irq1", {31'h0, irq}, 32'h1);
    check_eq("mp_addr", irq_addr, 32'h40);

    // re-edge on src[1] in the ack cycle
    src = 4'b0010; irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check_eq("col_gap", {31'h0, irq}, 32'h0);
    rd_chk("col_pend", IRQC_A_PEND, 32'h2);
    step();
    check_eq("col_idle", {31'h0, irq}, 32'h0);
    step();
    check_eq("col_req2", {31'h0, irq}, 32'h1);
    check_eq("col_addr2", irq_addr, 32'h40);
    src = 4'b0000;
    ack(); step();
    rd_chk("col_pend_end", IRQC_A_PEND, 32'h0);

    // stray ack while idle
    ack();
    check_eq("stray_irq", {31'h0, irq}, 32'h0);
    rd_chk("stray_pend", IRQC_A_PEND, 32'h0);
    rd_chk("stray_active", IRQC_A_ACTIVE, 32'h1);

    // priority: service 0 alone, then 0 and 3 together
    wr(IRQC_A_MASK, 32'hF);
    src = 4'b0001; step(); src = 4'b0000; step();
    check_eq("pri_pre_addr", irq_addr, 32'h0);
    check_eq("pri_pre_irq", {31'h0, irq}, 32'h1);
    ack(); step();
    src = 4'b1001; step(); src = 4'b0000; step();
    check_eq("pri_first_irq", {31'h0, irq}, 32'h1);
    check_eq("pri_first_addr", irq_addr, exp_first);
    ack();
    check_eq("pri_gap", {31'h0, irq}, 32'h0);
    step();
    check_eq("pri_idle", {31'h0, irq}, 32'h0);
    step();
    check_eq("pri_second_irq", {31'h0, irq}, 32'h1);
    check_eq("pri_second_addr", irq_addr, exp_second);
    ack(); step();
    rd_chk("pri_pend", IRQC_A_PEND, 32'h0);

    // W1C while idle
    wr(IRQC_A_MASK, 32'h0);
    src = 4'b0101; step(); src = 4'b0000; step();
    rd_chk("w1c_pre", IRQC_A_PEND, 32'h5);
    wr(IRQC_A_PEND, 32'h1);
    rd_chk("w1c_post", IRQC_A_PEND, 32'h4);
    wr(IRQC_A_PEND, 32'hF);
    rd_chk("w1c_all", IRQC_A_PEND, 32'h0);

    // W1C of active bit during REQ
    wr(IRQC_A_MASK, 32'h4);
    src = 4'b0100; step(); src = 4'b0000; step();
    check_eq("w1a_req", {31'h0, irq}, 32'h1);
    wr(IRQC_A_PEND, 32'h4);
    rd_chk("w1a_pend", IRQC_A_PEND, 32'h0);
    check_eq("w1a_hold", {31'h0, irq}, 32'h1);
    ack();
    check_eq("w1a_gap", {31'h0, irq}, 32'h0);
    step(); step();
    check_eq("w1a_quiet", {31'h0, irq}, 32'h0);

    // asynchronous reset in the middle of a request
    src = 4'b0100; step(); src = 4'b0000; step();
    check_eq("mr_req", {31'h0, irq}, 32'h1);
    #2 rst = 1'b0;
    #1;
    check_eq("mr_irq_drop", {31'h0, irq}, 32'h0);
    check_eq("mr_addr", irq_addr, 32'h0);
    step();
    rst = 1'b1;
    step();
    rd_chk("mr_mask", IRQC_A_MASK, 32'h0);
    rd_chk("mr_pend", IRQC_A_PEND, 32'h0);
    rd_chk("mr_active", IRQC_A_ACTIVE, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
